wb_grf: RTL

Write-back stage and general register file for the five-stage MIPS pipeline. The block consumes the outputs of the W pipeline register: instruction, PC+4, ALU result, DM read data and compare flags. It decodes the instruction, forms the write-back value (including load extension), and commits it to a 32×32 register file. The file serves two combinational read ports to the D stage, with W→D bypass, and keeps a retired-instruction counter.

---
 rtl/wb_grf.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_grf.sv
// Write-back stage decode and 32x32 general register file with W->D bypass and retire counter.
// Latency: we/wa/wd/pc and read ports are combinational; storage and retire count update at posedge.
// Backpressure: none; the block accepts one W instruction every cycle.
module wb_grf #(
  parameter logic [31:0] RST_GP  = 32'h0000_1800,
  parameter logic [31:0] RST_SP  = 32'h0000_2ffc,
  // Reset value of the retire counter; 0 in any real pipeline, nonzero only to exercise wrap.
  parameter logic [31:0] RST_RET = 32'h0000_0000
) (
  input  logic        wb_grf_clk_W_i,
  input  logic        wb_grf_rstn_W_i,
  input  logic [31:0] wb_grf_str_W_i,
  input  logic [31:0] wb_grf_pc4_W_i,
  input  logic [31:0] wb_grf_alo_W_i,
  input  logic [31:0] wb_grf_dmd_W_i,
  input  logic [1:0]  wb_grf_eal_W_i,
  input  logic [4:0]  wb_grf_ra1_D_i,
  input  logic [4:0]  wb_grf_ra2_D_i,
  output logic [31:0] wb_grf_rd1_D_o,
  output logic [31:0] wb_grf_rd2_D_o,
  output logic        wb_grf_we_W_o,
  output logic [4:0]  wb_grf_wa_W_o,
  output logic [31:0] wb_grf_wd_W_o,
  output logic [31:0] wb_grf_pc_W_o,
  output logic [31:0] wb_grf_ret_W_o
);

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        is_bubble;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic        wr_dec;
  logic [4:0]  wa_dec;
  logic [31:0] wd_dec;
  logic        we;

  logic [31:0] regs [32];
  logic [31:0] ret_q;

  // The equal flag is produced upstream for branches; write-back has no use for it.
  logic        unused_eal_eq;
  assign unused_eal_eq = wb_grf_eal_W_i[1];

  assign op        = wb_grf_str_W_i[31:26];
  assign rt        = wb_grf_str_W_i[20:16];
  assign rd        = wb_grf_str_W_i[15:11];
  assign funct     = wb_grf_str_W_i[5:0];
  assign is_bubble = (wb_grf_str_W_i == 32'h0);

  // Select the addressed byte and halfword of the raw DM word for sub-word loads.
  always_comb begin
    ld_byte = 8'h00;
    case (wb_grf_alo_W_i[1:0])
      2'd0:    ld_byte = wb_grf_dmd_W_i[7:0];
      2'd1:    ld_byte = wb_grf_dmd_W_i[15:8];
      2'd2:    ld_byte = wb_grf_dmd_W_i[23:16];
      default: ld_byte = wb_grf_dmd_W_i[31:24];
    endcase
    ld_half = wb_grf_alo_W_i[1] ? wb_grf_dmd_W_i[31:16] : wb_grf_dmd_W_i[15:0];
  end

  // Decode destination register and write-back value; non-writers leave all three at zero.
  always_comb begin
    wr_dec = 1'b0;
    wa_dec = 5'd0;
    wd_dec = 32'h0;
    if (!is_bubble) begin
      case (op)
        OP_SPECIAL: begin
          case (funct)
            FN_ADDU, FN_SUBU, FN_OR, FN_SLL: begin
              wr_dec = 1'b1;
              wa_dec = rd;
              wd_dec = wb_grf_alo_W_i;
            end
            FN_SLT: begin
              wr_dec = 1'b1;
              wa_dec = rd;
              wd_dec = {31'b0, wb_grf_eal_W_i[0]};
            end
            default: begin
              wr_dec = 1'b0;
            end
          endcase
        end
        OP_ORI, OP_ADDIU, OP_LUI: begin
          wr_dec = 1'b1;
          wa_dec = rt;
          wd_dec = wb_grf_alo_W_i;
        end
        OP_LW: begin
          wr_dec = 1'b1;
          wa_dec = rt;
          wd_dec = wb_grf_dmd_W_i;
        end
        OP_LB: begin
          wr_dec = 1'b1;
          wa_dec = rt;
          wd_dec = {{24{ld_byte[7]}}, ld_byte};
        end
        OP_LBU: begin
          wr_dec = 1'b1;
          wa_dec = rt;
          wd_dec = {24'h0, ld_byte};
        end
        OP_LH: begin
          wr_dec = 1'b1;
          wa_dec = rt;
          wd_dec = {{16{ld_half[15]}}, ld_half};
        end
        OP_LHU: begin
          wr_dec = 1'b1;
          wa_dec = rt;
          wd_dec = {16'h0, ld_half};
        end
        OP_JAL: begin
          wr_dec = 1'b1;
          wa_dec = 5'd31;
          wd_dec = wb_grf_pc4_W_i + 32'd4;
        end
        default: begin
          wr_dec = 1'b0;
        end
      endcase
    end
  end

  // $0 is hardwired, so a decoded write to it never enables the file.
  assign we = wr_dec && (wa_dec != 5'd0);

  assign wb_grf_we_W_o  = we;
  assign wb_grf_wa_W_o  = wa_dec;
  assign wb_grf_wd_W_o  = wd_dec;
  assign wb_grf_pc_W_o  = wb_grf_pc4_W_i - 32'd4;
  assign wb_grf_ret_W_o = ret_q;

  // Register storage: reset loads gp/sp seeds and beats any same-edge write.
  always_ff @(posedge wb_grf_clk_W_i) begin
    if (!wb_grf_rstn_W_i) begin
      for (int i = 0; i < 32; i++) begin
        if (i == 28)      regs[i] <= RST_GP;
        else if (i == 29) regs[i] <= RST_SP;
        else              regs[i] <= 32'h0;
      end
    end else if (we) begin
      regs[wa_dec] <= wd_dec;
    end
  end

  // Retire counter: counts every non-bubble instruction leaving W, wrapping naturally.
  always_ff @(posedge wb_grf_clk_W_i) begin
    if (!wb_grf_rstn_W_i) begin
      ret_q <= RST_RET;
    end else if (!is_bubble) begin
      ret_q <= ret_q + 32'd1;
    end
  end

  // Read ports: forward the W write in the same cycle so D never waits on write-back.
  always_comb begin
    if (wb_grf_ra1_D_i == 5'd0)
      wb_grf_rd1_D_o = 32'h0;
    else if (we && (wb_grf_ra1_D_i == wa_dec))
      wb_grf_rd1_D_o = wd_dec;
    else
      wb_grf_rd1_D_o = regs[wb_grf_ra1_D_i];

    if (wb_grf_ra2_D_i == 5'd0)
      wb_grf_rd2_D_o = 32'h0;
    else if (we && (wb_grf_ra2_D_i == wa_dec))
      wb_grf_rd2_D_o = wd_dec;
    else
      wb_grf_rd2_D_o = regs[wb_grf_ra2_D_i];
  end

endmodule
